poly_stream_ctrl: RTL and testbench
===================================

Name: poly_stream_ctrl

Overview:
- Sequencer directly upstream and downstream of polyunit_core.
- On run: reads two 256-coefficient polynomials from NTT RAM banks A and B, streams coefficient pairs into the core, and writes the reduced results to the destination bank.
- Owns address generation, RAM read-latency alignment, core-latency alignment, and the run/done handshake toward the top-level Kyber controller.

Parameters:
- WIDTH, 12, coefficient width (q = 3329 fits).
- N, 256, coefficients per polynomial.
- AW, 8, RAM address width; N must equal 2**AW.
- CORE_LAT, 2, cycles from op_valid to the matching core_res being valid (fixed pipeline depth of polyunit_core).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- run  in  1  start pulse; sampled only in IDLE.
- mode  in  2  00 add, 01 sub (A-B), 10 copy A, 11 reserved.
- busy  out  1  high from the cycle after run is accepted until the done cycle inclusive.
- done  out  1  single-cycle completion pulse.
- ram_a_addr  out  AW  read address, bank A.
- ram_b_addr  out  AW  read address, bank B.
- ram_rd  out  1  read strobe, both banks.
- ram_a_q  in  WIDTH  bank A read data; valid 1 cycle after ram_rd.
- ram_b_q  in  WIDTH  bank B read data; valid 1 cycle after ram_rd.
- op_a  out  WIDTH  operand A to core.
- op_b  out  WIDTH  operand B to core.
- op_valid  out  1  operand pair valid.
- core_mode  out  2  latched mode to core.
- core_res  in  WIDTH  core result, in [0, 3328].
- ram_w_addr  out  AW  destination write address.
- ram_w_en  out  1  write enable.
- ram_w_data  out  WIDTH  write data (= core_res).

Behaviour:
- Reset: the rst==0 clock edge forces state IDLE, all counters 0, core_mode 0, and every output 0.
- Reset mid-operation aborts immediately: no further ram_rd or ram_w_en, no done.
- States: IDLE -> FETCH -> DRAIN -> FIN -> IDLE.
- IDLE
  - run=1 with mode!=11: latch mode into core_mode, clear counters, go to FETCH.
  - run=1 with mode=11: ignored; stay in IDLE, done never asserted.
- FETCH
  - ram_rd=1; ram_a_addr = ram_b_addr = rd_cnt, starting at 0 and incrementing each cycle.
  - After issuing address N-1, go to DRAIN; rd_cnt wraps to 0 without being reused.
- Operand path
  - op_valid is ram_rd delayed 1 cycle.
  - op_a = ram_a_q; op_b = ram_b_q; in copy mode op_b is driven to 0.
- Write path
  - ram_w_en is op_valid delayed CORE_LAT cycles (shift register).
  - ram_w_data = core_res.
  - ram_w_addr = wr_cnt, incremented after each write.
- DRAIN: wait until wr_cnt has counted N writes, then go to FIN.
- FIN: done=1 for exactly one cycle, busy still 1; then IDLE.
- Timing
  - run sampled at edge 0; addresses 0..N-1 are issued in cycles 1..N.
  - Writes occur in cycles 2+CORE_LAT .. N+1+CORE_LAT.
  - done occurs in cycle N+2+CORE_LAT (260 with defaults).
- run asserted while busy is ignored; no restart, no queueing.
- Address ordering is strictly linear, and write order equals read order.
- wr_cnt is AW+1 bits wide so a count of N is distinguishable from 0.
- Throughput: one coefficient per cycle, no stalls.
- No arithmetic is done in this block; modular reduction belongs to the core.

Decomposition:
- Shared package poly_pkg:
  - Q=3329, N, AW.
  - Mode encodings MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_COPY=2'b10, MODE_RSV=2'b11.
  - FSM state encodings.
- One natural sub-module: poly_valid_delay, a parameterised 1-bit shift register of depth CORE_LAT used to align ram_w_en; instantiated once.
- Counters and FSM stay in the top module.

Test Plan:
- Add: A[i]=i, B[i]=3328, mode 00, behavioural core model.
  - Expect 256 writes with w_data[i]=(i+3328)%3329: addr 0 → 3328, addr 1 → 0.
  - Expect done at cycle 260 and busy high cycles 1..260.
- Sub: A[i]=0, B[i]=4095 clipped to 3328, mode 01.
  - Expect every written value = 1; ram_w_addr runs 0..255 exactly once, with no gaps.
- Copy: A[i]=3329-1-i, mode 10.
  - Expect op_b=0 throughout; destination equals A; core_mode=10 for the whole run.
- Reserved/overlap:
  - run with mode 11 → no ram_rd, busy=0, no done.
  - run re-pulsed at cycle 100 of a valid run → ignored; done still at 260, exactly 256 writes.
- Reset mid-run: rst=0 at cycle 50 for 1 cycle.
  - Expect all outputs 0 the next cycle, no writes or done afterwards.
  - A fresh run then completes normally with 256 writes.
- CORE_LAT=4 build: add run → first write at cycle 6, done at cycle 262.

Source files
------------

// File: rtl/poly_stream_ctrl_pkg.sv
// Shared constants, mode encodings and sequencer states for the polynomial
// streaming datapath around polyunit_core.
package poly_pkg;

  localparam int Q       = 3329;
  localparam int POLY_N  = 256;
  localparam int POLY_AW = 8;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_COPY = 2'b10;
  localparam logic [1:0] MODE_RSV  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/poly_stream_ctrl_valid_delay.sv
// Fixed-depth 1-bit shift register that lines the write strobe up with the
// output of the core pipeline.
module poly_valid_delay
  import poly_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/poly_stream_ctrl.sv
// Streams two polynomials from banks A/B through polyunit_core and writes the
// results back, one coefficient per cycle, with a run/busy/done handshake.
module poly_stream_ctrl
  import poly_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int N        = POLY_N,
  parameter int AW       = POLY_AW,
  parameter int CORE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    ram_a_addr,
  output logic [AW-1:0]    ram_b_addr,
  output logic             ram_rd,
  input  logic [WIDTH-1:0] ram_a_q,
  input  logic [WIDTH-1:0] ram_b_q,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  output logic [1:0]       core_mode,
  input  logic [WIDTH-1:0] core_res,
  output logic [AW-1:0]    ram_w_addr,
  output logic             ram_w_en,
  output logic [WIDTH-1:0] ram_w_data
);

  state_t        state;
  logic [AW-1:0] rd_cnt;
  logic [AW:0]   wr_cnt;
  logic [AW:0]   wr_nxt;
  logic          w_en;

  poly_valid_delay #(
    .DEPTH(CORE_LAT)
  ) u_wen_delay (
    .clk(clk),
    .rst(rst),
    .d  (op_valid),
    .q  (w_en)
  );

  // Look one write ahead so done lands in the cycle right after the last write.
  assign wr_nxt = wr_cnt + (AW+1)'(w_en);

  assign ram_a_addr = rd_cnt;
  assign ram_b_addr = rd_cnt;
  assign ram_w_addr = wr_cnt[AW-1:0];
  assign ram_w_en   = w_en;
  assign ram_w_data = w_en ? core_res : '0;
  assign op_a       = op_valid ? ram_a_q : '0;
  assign op_b       = (op_valid && core_mode != MODE_COPY) ? ram_b_q : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      core_mode <= MODE_ADD;
      ram_rd    <= 1'b0;
      op_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      op_valid <= ram_rd;
      wr_cnt   <= wr_nxt;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run && mode != MODE_RSV) begin
            core_mode <= mode;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            ram_rd    <= 1'b1;
            busy      <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (rd_cnt == AW'(N-1)) begin
            ram_rd <= 1'b0;
            rd_cnt <= '0;
            state  <= S_DRAIN;
          end else begin
            rd_cnt <= rd_cnt + AW'(1);
          end
        end
        S_DRAIN: begin
          if (wr_nxt == (AW+1)'(N)) begin
            done  <= 1'b1;
            state <= S_FIN;
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_stream_ctrl.sv
// Self-checking bench for poly_stream_ctrl: RAM banks and core are modelled
// behaviourally, and each run is scored against arithmetic expectations.
module tb_poly_stream_ctrl;
  import poly_pkg::*;

  localparam int NC = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
  logic run4 = 1'b0;
  logic [1:0] mode = 2'b00;

  logic busy, done, ram_rd, op_valid, ram_w_en;
  logic [7:0] ram_a_addr, ram_b_addr, ram_w_addr;
  logic [11:0] op_a, op_b, ram_w_data, core_res;
  logic [1:0] core_mode;
  logic [11:0] qa = '0;
  logic [11:0] qb = '0;

  logic busy4, done4, ram_rd4, op_valid4, w_en4;
  logic [7:0] a_addr4, b_addr4, w_addr4;
  logic [11:0] op_a4, op_b4, w_data4, core_res4;
  logic [1:0] core_mode4;
  logic [11:0] qa4 = '0;
  logic [11:0] qb4 = '0;

  logic [11:0] memA [NC];
  logic [11:0] memB [NC];
  logic [11:0] pipe  [2];
  logic [11:0] pipe4 [4];

  int cyc = 0;
  int passCount = 0;
  int totalCount = 0;
  int startCyc = 0;
  logic [1:0] curMode = 2'b00;

  logic [7:0]  wAddr [$];
  logic [11:0] wData [$];
  int          wCyc  [$];
  int doneCnt, doneCyc, busyCnt, busyFirst, rdCnt, opbBad, modeBad;
  int w4Cnt, w4First, done4Cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  poly_stream_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .mode(mode), .busy(busy), .done(done),
    .ram_a_addr(ram_a_addr), .ram_b_addr(ram_b_addr), .ram_rd(ram_rd),
    .ram_a_q(qa), .ram_b_q(qb), .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
    .core_mode(core_mode), .core_res(core_res), .ram_w_addr(ram_w_addr),
    .ram_w_en(ram_w_en), .ram_w_data(ram_w_data)
  );

  poly_stream_ctrl #(.CORE_LAT(4)) dut4 (
    .clk(clk), .rst(rst), .run(run4), .mode(mode), .busy(busy4), .done(done4),
    .ram_a_addr(a_addr4), .ram_b_addr(b_addr4), .ram_rd(ram_rd4),
    .ram_a_q(qa4), .ram_b_q(qb4), .op_a(op_a4), .op_b(op_b4), .op_valid(op_valid4),
    .core_mode(core_mode4), .core_res(core_res4), .ram_w_addr(w_addr4),
    .ram_w_en(w_en4), .ram_w_data(w_data4)
  );

  // Expected coefficient as the modular arithmetic defines it.
  function automatic logic [11:0] refCoef(input logic [1:0] m, input int a, input int b);
    case (m)
      2'b00:   return 12'((a + b) % Q);
      2'b01:   return 12'((a - b + Q) % Q);
      default: return 12'(a);
    endcase
  endfunction

  // Synchronous-read banks and fixed-depth core pipelines for both instances.
  always @(posedge clk) begin
    if (ram_rd) begin
      qa <= memA[ram_a_addr];
      qb <= memB[ram_b_addr];
    end
    if (ram_rd4) begin
      qa4 <= memA[a_addr4];
      qb4 <= memB[b_addr4];
    end
    pipe[0] <= refCoef(core_mode, int'(op_a), int'(op_b));
    pipe[1] <= pipe[0];
    pipe4[0] <= refCoef(core_mode4, int'(op_a4), int'(op_b4));
    for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
  end
  assign core_res  = pipe[1];
  assign core_res4 = pipe4[3];

  always @(negedge clk) begin
    if (ram_w_en) begin
      wAddr.push_back(ram_w_addr);
      wData.push_back(ram_w_data);
      wCyc.push_back(cyc);
    end
    if (done) begin
      doneCnt++;
      doneCyc = cyc;
    end
    if (busy) begin
      busyCnt++;
      if (busyFirst < 0) busyFirst = cyc;
      if (core_mode !== curMode) modeBad++;
    end
    if (ram_rd) rdCnt++;
    if (op_valid && curMode == MODE_COPY && op_b !== 12'd0) opbBad++;
    if (w_en4) begin
      w4Cnt++;
      if (w4First < 0) w4First = cyc;
    end
    if (done4) done4Cyc = cyc;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic clearMon();
    wAddr.delete();
    wData.delete();
    wCyc.delete();
    doneCnt = 0; doneCyc = -1; busyCnt = 0; busyFirst = -1;
    rdCnt = 0; opbBad = 0; modeBad = 0;
  endtask

  task automatic applyStimulus(input logic [1:0] m, input int repulseAt);
    clearMon();
    curMode = m;
    @(negedge clk);
    mode = m;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    startCyc = cyc;
    for (int k = 1; k < 600 && doneCnt == 0; k++) begin
      if (k == repulseAt) begin
        run = 1'b1;
        mode = MODE_COPY;
      end else begin
        run = 1'b0;
        mode = m;
      end
      @(negedge clk);
    end
    run = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic checkRun(input string tag);
    int addrErr = 0;
    int dataErr = 0;
    for (int i = 0; i < wData.size() && i < NC; i++) begin
      if (wAddr[i] !== 8'(i)) addrErr++;
      if (wData[i] !== refCoef(curMode, int'(memA[i]), int'(memB[i]))) dataErr++;
    end
    checkOutput({tag, "_nwrites"}, wData.size(), NC);
    checkOutput({tag, "_first_write_cycle"}, (wCyc.size() > 0) ? wCyc[0] - startCyc + 1 : -1, 4);
    checkOutput({tag, "_done_cycle"}, doneCyc - startCyc + 1, 260);
    checkOutput({tag, "_done_count"}, doneCnt, 1);
    checkOutput({tag, "_busy_first"}, busyFirst - startCyc + 1, 1);
    checkOutput({tag, "_busy_cycles"}, busyCnt, 260);
    checkOutput({tag, "_addr_errors"}, addrErr, 0);
    checkOutput({tag, "_data_errors"}, dataErr, 0);
    checkOutput({tag, "_core_mode_errors"}, modeBad, 0);
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      memA[i] = 12'(i);
      memB[i] = 12'd3328;
    end
    clearMon();
    w4Cnt = 0; w4First = -1; done4Cyc = -1;

    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ctrl", {busy, done, ram_rd, op_valid, ram_w_en, core_mode}, 0);
    checkOutput("rst_addr", {ram_a_addr, ram_b_addr, ram_w_addr}, 0);
    checkOutput("rst_data", {20'd0, op_a | op_b | ram_w_data}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] add run");
    applyStimulus(MODE_ADD, 0);
    checkRun("add");
    checkOutput("add_addr0", (wData.size() > 0) ? wData[0] : 12'hfff, 3328);
    checkOutput("add_addr1", (wData.size() > 1) ? wData[1] : 12'hfff, 0);

    $display("[TB] sub run");
    for (int i = 0; i < NC; i++) begin
      memA[i] = 12'd0;
      memB[i] = 12'd3328;
    end
    applyStimulus(MODE_SUB, 0);
    checkRun("sub");

    $display("[TB] copy run");
    for (int i = 0; i < NC; i++) begin
      memA[i] = 12'(3328 - i);
      memB[i] = 12'($urandom_range(1, 3328));
    end
    applyStimulus(MODE_COPY, 0);
    checkRun("copy");
    checkOutput("copy_opb_nonzero", opbBad, 0);

    $display("[TB] reserved mode");
    applyStimulus(MODE_RSV, 0);
    checkOutput("rsv_reads", rdCnt, 0);
    checkOutput("rsv_busy", busyCnt, 0);
    checkOutput("rsv_done", doneCnt, 0);

    $display("[TB] overlapping run pulse");
    for (int i = 0; i < NC; i++) begin
      memA[i] = 12'($urandom_range(0, 3328));
      memB[i] = 12'($urandom_range(0, 3328));
    end
    applyStimulus(MODE_ADD, 100);
    checkRun("overlap");

    $display("[TB] reset mid-run");
    clearMon();
    curMode = MODE_SUB;
    @(negedge clk);
    mode = MODE_SUB;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (49) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("midrst_ctrl", {busy, done, ram_rd, op_valid, ram_w_en, core_mode}, 0);
    checkOutput("midrst_data", {20'd0, op_a | op_b | ram_w_data}, 0);
    clearMon();
    repeat (300) @(negedge clk);
    checkOutput("midrst_writes", wData.size(), 0);
    checkOutput("midrst_done", doneCnt, 0);
    checkOutput("midrst_reads", rdCnt, 0);

    $display("[TB] fresh run after reset");
    for (int i = 0; i < NC; i++) begin
      memA[i] = 12'($urandom_range(0, 3328));
      memB[i] = 12'($urandom_range(0, 3328));
    end
    applyStimulus(2'($urandom_range(0, 2)), 0);
    checkRun("fresh");

    $display("[TB] CORE_LAT=4 instance");
    @(negedge clk);
    mode = MODE_ADD;
    run4 = 1'b1;
    @(negedge clk);
    run4 = 1'b0;
    startCyc = cyc;
    for (int k = 0; k < 600 && done4Cyc < 0; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    checkOutput("lat4_first_write", (w4First >= 0) ? w4First - startCyc + 1 : -1, 6);
    checkOutput("lat4_done_cycle", (done4Cyc >= 0) ? done4Cyc - startCyc + 1 : -1, 262);
    checkOutput("lat4_nwrites", w4Cnt, 256);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
